// File: rtl/cordic_arbiter.sv
// Round-robin controller sharing one cordic_core register bus between NUM_REQ requesters.
// Define CORDIC_ARB_TIMEOUT_EN to add a WAIT-state watchdog that answers with resp_err=1.
module cordic_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] angle_in,
  output logic [NUM_REQ-1:0]    ack,
  output logic [31:0]           cos_out,
  output logic [31:0]           sin_out,
  output logic [ID_W-1:0]       resp_id,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  core_write,
  output logic                  core_read,
  output logic [5:0]            core_addr,
  output logic [31:0]           core_wdata,
  input  logic [31:0]           core_rdata,
  input  logic                  core_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RD_COS, S_RD_SIN, S_ACK
  } state_t;

  state_t state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [ID_W:0]     grant;
  logic signed [31:0] angle_q, angle_d;
  logic signed [31:0] cos_cap_q, cos_cap_d;
  logic signed [31:0] cos_out_q, cos_out_d;
  logic signed [31:0] sin_out_q, sin_out_d;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Returns {found, index} of the first set request at or after p, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [ID_W-1:0]    p);
    logic [ID_W:0] res;
    int j;
    res = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      j = int'(p) + off;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (k == j && r[k]) res = {1'b1, ID_W'(k)};
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    resp_id_d = resp_id_q;
    angle_d   = angle_q;
    cos_cap_d = cos_cap_q;
    cos_out_d = cos_out_q;
    sin_out_d = sin_out_q;
    grant     = rr_pick(req, ptr_q);
`ifdef CORDIC_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant[ID_W]) begin
          id_d = grant[ID_W-1:0];
          for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[ID_W-1:0] == ID_W'(k)) angle_d = angle_in[32*k +: 32];
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      S_WAIT: begin
        // done is a single-cycle pulse, so it must win over the watchdog
        if (core_done) state_d = S_RD_COS;
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = S_ACK;
          cos_out_d = '0;
          sin_out_d = '0;
          resp_id_d = id_q;
          err_d     = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
`endif
      end
      S_RD_COS: begin
        cos_cap_d = core_rdata;
        state_d   = S_RD_SIN;
      end
      S_RD_SIN: begin
        // Results move to the outputs together so they only change in the ack cycle
        cos_out_d = cos_cap_q;
        sin_out_d = core_rdata;
        resp_id_d = id_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
        err_d = 1'b0;
`endif
        state_d = S_ACK;
      end
      S_ACK: begin
        ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_write = 1'b0;
    core_read  = 1'b0;
    core_addr  = 6'h00;
    core_wdata = '0;
    case (state_q)
      S_ISSUE: begin
        core_write = 1'b1;
        core_addr  = 6'h04;
        core_wdata = angle_q;
      end
      S_RD_COS: begin
        core_read = 1'b1;
        core_addr = 6'h08;
      end
      S_RD_SIN: begin
        core_read = 1'b1;
        core_addr = 6'h0C;
      end
      default: ;
    endcase
    // Strobes drop in the reset cycle itself, not one cycle later
    if (rst) begin
      core_write = 1'b0;
      core_read  = 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      ack[k] = (state_q == S_ACK) && (id_q == ID_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      resp_id_q <= '0;
      cos_out_q <= '0;
      sin_out_q <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      resp_id_q <= resp_id_d;
      cos_out_q <= cos_out_d;
      sin_out_q <= sin_out_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    angle_q   <= angle_d;
    cos_cap_q <= cos_cap_d;
  end

  assign cos_out = cos_out_q;
  assign sin_out = sin_out_q;
  assign resp_id = resp_id_q;
  assign busy    = (state_q != S_IDLE);
`ifdef CORDIC_ARB_TIMEOUT_EN
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: stub cordic_core, transaction-timeline model and directed scenarios.
module tb_cordic_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] angle_in;
  logic [NUM_REQ-1:0]    ack;
  logic [31:0]           cos_out, sin_out, core_wdata, core_rdata;
  logic [ID_W-1:0]       resp_id;
  logic                  resp_err, busy, core_write, core_read, core_done;
  logic [5:0]            core_addr;

  always #5 clk = ~clk;

  cordic_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .angle_in(angle_in), .ack(ack),
    .cos_out(cos_out), .sin_out(sin_out), .resp_id(resp_id), .resp_err(resp_err),
    .busy(busy), .core_write(core_write), .core_read(core_read),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_done(core_done)
  );

  // Stub core: results derived from the written angle, done stub_lat cycles after the write
  function automatic logic [31:0] f_cos(input logic [31:0] a);
    return {16'h0000, a[31:16]} ^ 32'h0000_3111;
  endfunction
  function automatic logic [31:0] f_sin(input logic [31:0] a);
    return {16'h0000, a[31:16]} ^ 32'h0000_0222;
  endfunction

  int          stub_lat = 17;
  int          stub_cnt = 0;
  logic [31:0] stub_w   = '0;
  int          cyc      = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) stub_cnt <= 0;
    else if (core_write) begin
      stub_w   <= core_wdata;
      stub_cnt <= stub_lat;
    end else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
  end
  assign core_done  = (stub_cnt == 1);
  assign core_rdata = (core_addr == 6'h08) ? f_cos(stub_w) :
                      (core_addr == 6'h0C) ? f_sin(stub_w) : 32'hDEAD_BEEF;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transaction is a grant cycle g, a write at g+1, the done cycle D,
  // reads at D+1/D+2 and the ack at D+3 (or g+2+TIMEOUT with the watchdog).
  logic [NUM_REQ-1:0] last_ack = '0;
  logic [NUM_REQ-1:0] hold = '0;
  int                 ack_cyc_log[$];
  int                 id_log[$];
  logic [31:0]        wr_log[$];

  bit              started = 0;
  bit              m_act = 0;
  int              m_g, m_done, m_ptr, ack_at, d, kk;
  bit              was_idle, found;
  logic [ID_W-1:0] m_id, m_rid;
  logic [31:0]     m_ang, m_cos, m_sin;
  logic            m_err;
  logic [NUM_REQ-1:0] e_ack;
  logic            e_busy, e_wr, e_rd;
  logic [5:0]      e_addr;
  logic [31:0]     e_wd;

  always @(negedge clk) begin
    last_ack = ack;
    if (core_write) wr_log.push_back(core_wdata);
    if (ack != '0) begin
      ack_cyc_log.push_back(cyc);
      id_log.push_back(int'(resp_id));
    end
    if (rst) begin
      if (started) begin
        chk("write_in_rst", {31'd0, core_write}, 32'd0);
        chk("read_in_rst", {31'd0, core_read}, 32'd0);
      end
      started = 1;
      m_act = 0; m_ptr = 0; m_cos = '0; m_sin = '0; m_rid = '0; m_err = 1'b0;
    end else if (started) begin
      e_ack = '0; e_busy = 1'b0; e_wr = 1'b0; e_rd = 1'b0; e_addr = 6'h00; e_wd = '0;
      was_idle = !m_act;
      if (m_act) begin
        e_busy = 1'b1;
        d = cyc - m_g;
        if (d == 1) begin
          e_wr = 1'b1; e_addr = 6'h04; e_wd = m_ang;
        end else begin
          if (m_done < 0 && core_done) m_done = cyc;
          ack_at = (m_done >= 0) ? m_done + 3 : -1;
`ifdef CORDIC_ARB_TIMEOUT_EN
          if (m_done < 0 && d == TIMEOUT + 2) ack_at = cyc;
`endif
          if (m_done >= 0 && cyc == m_done + 1) begin e_rd = 1'b1; e_addr = 6'h08; end
          if (m_done >= 0 && cyc == m_done + 2) begin e_rd = 1'b1; e_addr = 6'h0C; end
          if (cyc == ack_at) begin
            e_ack[m_id] = 1'b1;
            m_rid = m_id;
            m_err = (m_done < 0);
            m_cos = m_err ? 32'd0 : f_cos(m_ang);
            m_sin = m_err ? 32'd0 : f_sin(m_ang);
            m_ptr = (int'(m_id) + 1) % NUM_REQ;
            m_act = 0;
          end
        end
      end
      chk("ack", {28'd0, ack}, {28'd0, e_ack});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("core_write", {31'd0, core_write}, {31'd0, e_wr});
      chk("core_read", {31'd0, core_read}, {31'd0, e_rd});
      chk("core_addr", {26'd0, core_addr}, {26'd0, e_addr});
      chk("core_wdata", core_wdata, e_wd);
      chk("cos_out", cos_out, m_cos);
      chk("sin_out", sin_out, m_sin);
      chk("resp_id", {30'd0, resp_id}, {30'd0, m_rid});
      chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
      if (was_idle && req != '0) begin
        found = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
          kk = (m_ptr + off) % NUM_REQ;
          if (!found && req[kk]) begin
            found = 1;
            m_id = ID_W'(kk);
          end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
          if (k == int'(m_id)) m_ang = angle_in[32*k +: 32];
        end
        m_g = cyc; m_done = -1; m_act = 1;
      end
    end
  end

  // Advance one cycle; a requester drops req in the cycle after its ack unless held
  task automatic step();
    @(posedge clk);
    #1;
    req = req & ~(last_ack & ~hold);
  endtask

  task automatic wait_ack(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        at = cyc;
        break;
      end
      step();
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_wait: got no ack within %0d cycles, want one (cycle %0d)", limit, cyc);
    end
  endtask

  task automatic set_angle(input int k, input logic [31:0] a);
    angle_in[32*k +: 32] = a;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int g, at, i0, w0, a0, busy_low, n_ack;
  logic [31:0] angs [4];

  initial begin
    rst = 1'b1; req = '0; angle_in = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_cos", cos_out, 32'd0);
    chk("rst_addr", {26'd0, core_addr}, 32'd0);
    chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
    step();

    // Single request
    set_angle(0, 32'h2000_0000);
    req = 4'b0001; g = cyc; w0 = wr_log.size();
    wait_ack(60, at);
    chk("t1_latency", at - g, 32'd21);
    chk("t1_ack", {28'd0, ack}, 32'd1);
    chk("t1_cos", cos_out, 32'h0000_1111);
    chk("t1_sin", sin_out, 32'h0000_2222);
    chk("t1_resp_id", {30'd0, resp_id}, 32'd0);
    chk("t1_writes", wr_log.size() - w0, 32'd1);
    if (wr_log.size() > w0) chk("t1_wdata", wr_log[w0], 32'h2000_0000);
    step(); step();

    // Four simultaneous requests from pointer 0
    pulse_reset();
    angs[0] = 32'h1000_0000; angs[1] = 32'h3000_0000;
    angs[2] = 32'h5000_0000; angs[3] = 32'h7000_0000;
    for (int k = 0; k < 4; k++) set_angle(k, angs[k]);
    i0 = id_log.size(); w0 = wr_log.size();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(60, at);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      if (id_log.size() > i0 + k) chk("t2_order", id_log[i0 + k], k);
      if (wr_log.size() > w0 + k) chk("t2_wdata", wr_log[w0 + k], angs[k]);
    end
    chk("t2_writes", wr_log.size() - w0, 32'd4);

    // Fairness: req0 held, req2 asserted once
    set_angle(0, 32'h0100_0000); set_angle(2, 32'h0200_0000);
    i0 = id_log.size();
    hold = 4'b0001; req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      wait_ack(60, at);
      if (k == 2) hold = '0;
      step();
    end
    if (id_log.size() > i0 + 2) begin
      chk("t3_first", id_log[i0], 32'd0);
      chk("t3_second", id_log[i0 + 1], 32'd2);
      chk("t3_third", id_log[i0 + 2], 32'd0);
    end
    step();

    // Reset in WAIT
    set_angle(1, 32'h0900_0000);
    req = 4'b0010; g = cyc; a0 = ack_cyc_log.size();
    repeat (5) step();
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_ack", {28'd0, ack}, 32'd0);
    chk("t4_write", {31'd0, core_write}, 32'd0);
    repeat (30) step();
    chk("t4_no_ack", ack_cyc_log.size() - a0, 32'd0);

    // Reset in ISSUE: the write strobe drops in the reset cycle
    set_angle(3, 32'h0A00_0000);
    req = 4'b1000;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_write_in_issue_rst", {31'd0, core_write}, 32'd0);
    req = '0;
    step();
    rst = 1'b0;
    step();

    // Fresh request after reset
    set_angle(3, 32'h4000_0000);
    req = 4'b1000; g = cyc;
    wait_ack(60, at);
    chk("t4_latency", at - g, 32'd21);
    chk("t4_resp_id", {30'd0, resp_id}, 32'd3);
    chk("t4_cos", cos_out, 32'h0000_7111);
    chk("t4_sin", sin_out, 32'h0000_4222);
    step(); step();

    // Core never answers
    stub_lat = 0;
    set_angle(2, 32'h6000_0000);
    req = 4'b0100; g = cyc;
`ifdef CORDIC_ARB_TIMEOUT_EN
    wait_ack(120, at);
    chk("t5_latency", at - g, 32'd66);
    chk("t5_err", {31'd0, resp_err}, 32'd1);
    chk("t5_cos", cos_out, 32'd0);
    chk("t5_sin", sin_out, 32'd0);
    chk("t5_resp_id", {30'd0, resp_id}, 32'd2);
    step();
`else
    busy_low = 0; n_ack = 0;
    step();
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (ack != '0) n_ack++;
      step();
    end
    chk("t5_no_ack", n_ack, 32'd0);
    chk("t5_busy_held", busy_low, 32'd0);
    req = '0;
    pulse_reset();
`endif
    stub_lat = 17;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
